br_resv_station: RTL
====================

Name: br_resv_station

Overview:
- Multi-entry, multi-thread branch reservation station: successor to the single-entry branch unit.
- Accepts branch/jump ops from issue and wakes up operands from the CDB.
- Selects the oldest ready entry, resolves the next PC (conditional compare or JALR target) and pushes {thread_id, pc_n, taken} into an internal output FIFO drained by fetch via out_ack.
- Supports per-thread flush of both the station and the queued results.

Parameters:
XLEN, 32, data/address width
NUM_ENTRIES, 4, reservation entries (>=2)
TAG_W, 4, CDB/ROB tag width
TID_W, 3, thread id width
OUT_DEPTH, 4, output FIFO depth (power of two)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
issue_en  in  1  issue request; accepted only when issue_rdy=1
issue_rdy  out  1  at least one free entry
issue_is_branch  in  1  1=conditional branch, 0=JALR
issue_op  in  3  funct3: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU
issue_thread_id  in  TID_W  owning thread
issue_pc  in  XLEN  instruction PC
issue_offset  in  XLEN  sign-extended immediate
issue_v1, issue_v2  in  XLEN  operand values
issue_v1_rdy, issue_v2_rdy  in  1  operand valid
issue_q1, issue_q2  in  TAG_W  producer tags when not ready
cdb_valid  in  1  CDB broadcast valid
cdb_tag  in  TAG_W  CDB tag
cdb_value  in  XLEN  CDB value
flush  in  1  kill everything owned by flush_tid
flush_tid  in  TID_W  thread to flush
out_valid  out  1  output FIFO head valid
out_thread_id  out  TID_W  head thread id
out_pc_n  out  XLEN  head resolved next PC
out_taken  out  1  head taken (JALR always 1)
out_ack  in  1  pop head; ignored when out_valid=0
busy_count  out  $clog2(NUM_ENTRIES+1)  occupied entries

Behaviour:
- Reset: all entries free, age matrix cleared, FIFO empty with pointers at 0; outputs out_valid=0, issue_rdy=1, busy_count=0, out_thread_id/out_pc_n/out_taken=0.
- Entry fields: busy, tid, is_branch, op, pc, offset, v1/v2, v1_rdy/v2_rdy, q1/q2.
- Allocation: issue_en&&issue_rdy writes the lowest-index free entry at the clock edge.
- Issue-time forwarding: an operand that is not ready but has cdb_valid && q==cdb_tag in the same cycle is captured from cdb_value with rdy=1.
- Wakeup: each cycle, every busy entry with rdy=0 and q==cdb_tag while cdb_valid latches cdb_value and sets rdy. Both operands may wake on one broadcast.
- Age: on allocation of entry i, older[i][j]=busy[j] for all j; freeing entry j clears column j.
- Select: an entry is ready when busy&&v1_rdy&&v2_rdy, using registered state only (no same-cycle CDB bypass into select). Pick the ready entry with no older ready entry. Dispatch occurs when at least one entry is ready and the FIFO is not full (no pop pass-through). The dispatched entry is freed at the same edge.
- Resolve (combinational on the selected entry): taken = compare(op, v1, v2) with signed LT/GE for 100/101 and unsigned for 110/111; pc_n = taken ? pc+offset : pc+4.
- JALR resolve: pc_n = (v1+offset) with bit0 cleared; taken=1. All adds wrap modulo 2^XLEN.
- Undefined funct3 (010/011): taken=0.
- Latency: issue with both operands ready in cycle c → dispatch in c+1 → out_valid in c+2. A CDB wakeup in cycle c allows dispatch no earlier than c+1.
- Output FIFO: each slot holds {tid, pc_n, taken, kill}.
  - Pop occurs on out_ack&&out_valid.
  - A head slot with kill=1 is popped automatically and never shown; out_valid = !empty && !head.kill.
- Flush: all busy entries with tid==flush_tid are freed at the edge, and all FIFO slots with that tid get kill=1.
  - An issue of flush_tid in the same cycle is dropped.
  - A dispatch of a flush_tid entry in the same cycle is suppressed (not written to the FIFO).
  - Other threads are unaffected.
- Simultaneous allocation and dispatch in one cycle are both performed; busy_count nets to unchanged.
- Full: issue_rdy=0 when all entries are busy; issue_en is ignored. issue_rdy does not look ahead to a same-cycle dispatch.
- Reset mid-operation: all entries and FIFO contents are discarded immediately (async); out_valid drops in the same cycle as rst assertion.

Test Plan:
- Ready BEQ, v1=v2=5, pc=0x100, offset=0x20, tid=2 → out_valid 2 cycles after issue; pc_n=0x120, taken=1, tid=2.
- BLT v1=0xFFFFFFFF, v2=1 → taken=1. Same operands with BLTU → taken=0, pc_n=pc+4.
- JALR v1=0x1001, offset=4 → pc_n=0x1004, taken=1. Operand wakeup: v1 waits on tag 3, cdb_valid with tag 3 and value 0x2000 → dispatch the next cycle, pc_n=0x2004.
- Age ordering: fill 4 entries with both operands pending; wake them in the order 3,1 on the same CDB tag → results pop in allocation order (1 before 3). With the 4 entries full, issue_rdy=0 and an extra issue is ignored.
- Backpressure: out_ack held 0 → FIFO fills to OUT_DEPTH and dispatch stalls. Pulse out_ack once → exactly one new result is enqueued the following cycle.
- Flush tid=1 with two tid-1 entries in the station and one tid-1 result queued behind a tid-0 result → only the tid-0 result appears and busy_count drops by 2. Assert rst mid-stream → out_valid=0 and busy_count=0 immediately.

Source files
------------

// File: rtl/br_resv_station.sv
// Multi-thread branch reservation station: CDB wakeup, oldest-ready select, branch/JALR
// resolve, and an output FIFO whose slots can be killed per thread.
module br_resv_station #(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned NUM_ENTRIES = 4,
   parameter int unsigned TAG_W       = 4,
   parameter int unsigned TID_W       = 3,
   parameter int unsigned OUT_DEPTH   = 4
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             issue_en,
   output logic                             issue_rdy,
   input  logic                             issue_is_branch,
   input  logic [2:0]                       issue_op,
   input  logic [TID_W-1:0]                 issue_thread_id,
   input  logic [XLEN-1:0]                  issue_pc,
   input  logic [XLEN-1:0]                  issue_offset,
   input  logic [XLEN-1:0]                  issue_v1,
   input  logic [XLEN-1:0]                  issue_v2,
   input  logic                             issue_v1_rdy,
   input  logic                             issue_v2_rdy,
   input  logic [TAG_W-1:0]                 issue_q1,
   input  logic [TAG_W-1:0]                 issue_q2,
   input  logic                             cdb_valid,
   input  logic [TAG_W-1:0]                 cdb_tag,
   input  logic [XLEN-1:0]                  cdb_value,
   input  logic                             flush,
   input  logic [TID_W-1:0]                 flush_tid,
   output logic                             out_valid,
   output logic [TID_W-1:0]                 out_thread_id,
   output logic [XLEN-1:0]                  out_pc_n,
   output logic                             out_taken,
   input  logic                             out_ack,
   output logic [$clog2(NUM_ENTRIES+1)-1:0] busy_count
);
   localparam int unsigned IdxW = $clog2(NUM_ENTRIES);
   localparam int unsigned PtrW = $clog2(OUT_DEPTH);
   localparam int unsigned CntW = $clog2(NUM_ENTRIES+1);

   logic [NUM_ENTRIES-1:0] busy_q, is_br_q, r1_q, r2_q;
   logic [TID_W-1:0]       tid_q [NUM_ENTRIES];
   logic [2:0]             op_q  [NUM_ENTRIES];
   logic [XLEN-1:0]        pc_q  [NUM_ENTRIES];
   logic [XLEN-1:0]        off_q [NUM_ENTRIES];
   logic [XLEN-1:0]        v1_q  [NUM_ENTRIES];
   logic [XLEN-1:0]        v2_q  [NUM_ENTRIES];
   logic [TAG_W-1:0]       q1_q  [NUM_ENTRIES];
   logic [TAG_W-1:0]       q2_q  [NUM_ENTRIES];
   // older_q[i][j] set means entry j was allocated before entry i
   logic [NUM_ENTRIES-1:0] older_q [NUM_ENTRIES];

   logic [TID_W-1:0] f_tid_q [OUT_DEPTH];
   logic [XLEN-1:0]  f_pc_q  [OUT_DEPTH];
   logic [OUT_DEPTH-1:0] f_tkn_q, f_kill_q;
   logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [PtrW:0]    cnt_q;

   logic                   have_free, found, dispatch, push, pop, alloc, fifo_full, fifo_empty;
   logic [IdxW-1:0]        free_idx, sel_idx;
   logic [NUM_ENTRIES-1:0] ready, disp_vec, flush_hit, free_vec;
   logic                   fwd1, fwd2, br_taken, res_taken;
   logic [XLEN-1:0]        sel_v1, sel_v2, sel_pc, sel_off, jalr_sum, res_pc;

   assign ready     = busy_q & r1_q & r2_q;
   assign issue_rdy = have_free;
   assign fwd1      = !issue_v1_rdy && cdb_valid && (issue_q1 == cdb_tag);
   assign fwd2      = !issue_v2_rdy && cdb_valid && (issue_q2 == cdb_tag);
   assign alloc     = issue_en && have_free && !(flush && (issue_thread_id == flush_tid));

   always_comb begin
      have_free = 1'b0;
      free_idx  = '0;
      found     = 1'b0;
      sel_idx   = '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         if (!busy_q[i] && !have_free) begin
            have_free = 1'b1;
            free_idx  = IdxW'(i);
         end
         if (ready[i] && ((older_q[i] & ready) == '0) && !found) begin
            found   = 1'b1;
            sel_idx = IdxW'(i);
         end
      end
   end

   assign fifo_full  = (cnt_q == (PtrW+1)'(OUT_DEPTH));
   assign fifo_empty = (cnt_q == '0);
   assign dispatch   = found && !fifo_full;
   assign push       = dispatch && !(flush && (tid_q[sel_idx] == flush_tid));
   assign pop        = !fifo_empty && (f_kill_q[rd_ptr_q] || out_ack);

   always_comb begin
      busy_count = '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         disp_vec[i]  = dispatch && (sel_idx == IdxW'(i));
         flush_hit[i] = flush && busy_q[i] && (tid_q[i] == flush_tid);
         busy_count   = busy_count + CntW'(busy_q[i]);
      end
      free_vec = disp_vec | flush_hit;
   end

   always_comb begin
      sel_v1   = v1_q[sel_idx];
      sel_v2   = v2_q[sel_idx];
      sel_pc   = pc_q[sel_idx];
      sel_off  = off_q[sel_idx];
      jalr_sum = sel_v1 + sel_off;
      br_taken = 1'b0;
      case (op_q[sel_idx])
         3'b000:  br_taken = (sel_v1 == sel_v2);
         3'b001:  br_taken = (sel_v1 != sel_v2);
         3'b100:  br_taken = ($signed(sel_v1) < $signed(sel_v2));
         3'b101:  br_taken = ($signed(sel_v1) >= $signed(sel_v2));
         3'b110:  br_taken = (sel_v1 < sel_v2);
         3'b111:  br_taken = (sel_v1 >= sel_v2);
         default: br_taken = 1'b0;
      endcase
      if (is_br_q[sel_idx]) begin
         res_taken = br_taken;
         res_pc    = br_taken ? (sel_pc + sel_off) : (sel_pc + XLEN'(4));
      end else begin
         res_taken = 1'b1;
         res_pc    = {jalr_sum[XLEN-1:1], 1'b0};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q  <= '0;
         is_br_q <= '0;
         r1_q    <= '0;
         r2_q    <= '0;
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            tid_q[i]   <= '0;
            op_q[i]    <= '0;
            pc_q[i]    <= '0;
            off_q[i]   <= '0;
            v1_q[i]    <= '0;
            v2_q[i]    <= '0;
            q1_q[i]    <= '0;
            q2_q[i]    <= '0;
            older_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (free_vec[i]) busy_q[i] <= 1'b0;
            if (busy_q[i] && cdb_valid) begin
               if (!r1_q[i] && (q1_q[i] == cdb_tag)) begin
                  v1_q[i] <= cdb_value;
                  r1_q[i] <= 1'b1;
               end
               if (!r2_q[i] && (q2_q[i] == cdb_tag)) begin
                  v2_q[i] <= cdb_value;
                  r2_q[i] <= 1'b1;
               end
            end
            for (int j = 0; j < NUM_ENTRIES; j++) begin
               if (free_vec[j]) older_q[i][j] <= 1'b0;
            end
            if (alloc && (free_idx == IdxW'(i))) begin
               busy_q[i]  <= 1'b1;
               is_br_q[i] <= issue_is_branch;
               tid_q[i]   <= issue_thread_id;
               op_q[i]    <= issue_op;
               pc_q[i]    <= issue_pc;
               off_q[i]   <= issue_offset;
               v1_q[i]    <= fwd1 ? cdb_value : issue_v1;
               v2_q[i]    <= fwd2 ? cdb_value : issue_v2;
               r1_q[i]    <= issue_v1_rdy | fwd1;
               r2_q[i]    <= issue_v2_rdy | fwd2;
               q1_q[i]    <= issue_q1;
               q2_q[i]    <= issue_q2;
               older_q[i] <= busy_q & ~free_vec;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         f_tkn_q  <= '0;
         f_kill_q <= '0;
         for (int k = 0; k < OUT_DEPTH; k++) begin
            f_tid_q[k] <= '0;
            f_pc_q[k]  <= '0;
         end
      end else begin
         if (flush) begin
            for (int k = 0; k < OUT_DEPTH; k++) begin
               if (f_tid_q[k] == flush_tid) f_kill_q[k] <= 1'b1;
            end
         end
         // A push always lands in an empty slot, so it overrides any stale kill mark
         if (push) begin
            f_tid_q[wr_ptr_q]  <= tid_q[sel_idx];
            f_pc_q[wr_ptr_q]   <= res_pc;
            f_tkn_q[wr_ptr_q]  <= res_taken;
            f_kill_q[wr_ptr_q] <= 1'b0;
            wr_ptr_q           <= wr_ptr_q + PtrW'(1);
         end
         if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
         cnt_q <= cnt_q + (PtrW+1)'(push) - (PtrW+1)'(pop);
      end
   end

   assign out_valid     = !fifo_empty && !f_kill_q[rd_ptr_q];
   assign out_thread_id = f_tid_q[rd_ptr_q];
   assign out_pc_n      = f_pc_q[rd_ptr_q];
   assign out_taken     = f_tkn_q[rd_ptr_q];

endmodule
